// File: rtl/verdict_pkg.sv
// Shared types for the verdict collector: frame header, serializer states, record layout.
// The record's ts field exists only when VERDICT_TS_EN is defined.
package verdict_pkg;

    localparam logic [7:0] HDR_BYTE = 8'hA5;

    localparam int unsigned DEF_NUM_OUTPUTS = 4;
    localparam int unsigned DEF_DATA_W      = 64;
    localparam int unsigned DEF_TS_W        = 32;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_MASK,
        S_TS,
        S_DATA
    } ser_state_t;

    typedef struct packed {
`ifdef VERDICT_TS_EN
        logic [DEF_TS_W-1:0]                        ts;
`endif
        logic [DEF_NUM_OUTPUTS-1:0]                 mask;
        logic [DEF_NUM_OUTPUTS-1:0][DEF_DATA_W-1:0] data;
    } verdict_rec_t;

    // Lowest set bit of mask at or above index 'from'; 8 when there is none.
    function automatic logic [3:0] next_set(input logic [7:0] mask, input logic [3:0] from);
        logic [3:0] idx;
        logic       found;
        idx   = 4'd8;
        found = 1'b0;
        for (int unsigned i = 0; i < 8; i++) begin
            if (!found && 4'(i) >= from && mask[i]) begin
                idx   = 4'(i);
                found = 1'b1;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/verdict_collector_if.sv
// Byte stream from the verdict collector toward the UART/trace sink.
interface verdict_collector_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (output tx_data, output tx_valid, input tx_ready);
    modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/verdict_fifo.sv
// Record queue; a push while full is still accepted when a pop happens on the same edge.
module verdict_fifo
    import verdict_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    parameter type         rec_t = verdict_rec_t
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  rec_t wr_data,
    input  logic pop,
    output rec_t rd_data,
    output logic full,
    output logic empty
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    rec_t        mem [DEPTH];
    logic        do_push;
    logic        do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rd_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
    end
endmodule

// File: rtl/verdict_collector.sv
// Captures active RTLola verdicts into a queue and serializes them as byte frames.
// Define VERDICT_TS_EN to add the cycle timestamp counter and TS field to every frame.
module verdict_collector
    import verdict_pkg::*;
#(
    parameter int unsigned NUM_OUTPUTS = 4,
    parameter int unsigned DATA_W      = 64,
    parameter int unsigned TS_W        = 32,
    parameter int unsigned FIFO_DEPTH  = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en,
    input  logic [NUM_OUTPUTS*DATA_W-1:0] out_data,
    input  logic [NUM_OUTPUTS-1:0]        out_aktv,
    verdict_collector_if.master           tx,
    output logic                          overflow,
    output logic [15:0]                   drop_cnt
);
    localparam int unsigned DATA_BYTES  = DATA_W / 8;
    localparam int unsigned FIELD_BYTES = ((TS_W > DATA_W) ? TS_W : DATA_W) / 8;
    localparam int unsigned CNT_W       = $clog2(FIELD_BYTES) + 1;

    typedef struct packed {
`ifdef VERDICT_TS_EN
        logic [TS_W-1:0]                    ts;
`endif
        logic [NUM_OUTPUTS-1:0]             mask;
        logic [NUM_OUTPUTS-1:0][DATA_W-1:0] data;
    } rec_t;

    ser_state_t       state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [3:0]       out_idx, idx_n;
    rec_t             frame, rec_in, rd_data;
    logic             push_req, pop, full, empty, drop;
    logic             fire, frame_done;
    logic [3:0]       first_idx, after_idx;
    logic [DATA_W-1:0] cur_word;
    logic [7:0]       data_byte;

`ifdef VERDICT_TS_EN
    localparam int unsigned TS_BYTES = TS_W / 8;
    logic [TS_W-1:0] ts;
    logic [7:0]      ts_byte;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)    ts <= '0;
        else if (en) ts <= ts + TS_W'(1);
    end
`endif

    always_comb begin
        rec_in      = '0;
`ifdef VERDICT_TS_EN
        rec_in.ts   = ts;
`endif
        rec_in.mask = out_aktv;
        rec_in.data = out_data;
    end

    assign push_req = en && (out_aktv != '0);
    assign drop     = push_req && full && !pop;

    verdict_fifo #(
        .DEPTH (FIFO_DEPTH),
        .rec_t (rec_t)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push_req),
        .wr_data (rec_in),
        .pop     (pop),
        .rd_data (rd_data),
        .full    (full),
        .empty   (empty)
    );

    always_comb begin
        cur_word  = '0;
        data_byte = '0;
        for (int unsigned i = 0; i < NUM_OUTPUTS; i++) begin
            if (out_idx == 4'(i)) cur_word = frame.data[i];
        end
        for (int unsigned b = 0; b < DATA_BYTES; b++) begin
            if (cnt == CNT_W'(b)) data_byte = cur_word[8*b +: 8];
        end
`ifdef VERDICT_TS_EN
        ts_byte = '0;
        for (int unsigned b = 0; b < TS_BYTES; b++) begin
            if (cnt == CNT_W'(b)) ts_byte = frame.ts[8*b +: 8];
        end
`endif
    end

    // The last byte of a frame chains straight into the next header when more records wait.
    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        idx_n       = out_idx;
        pop         = 1'b0;
        frame_done  = 1'b0;
        tx.tx_valid = (state != S_IDLE);
        tx.tx_data  = '0;
        fire        = tx.tx_valid && tx.tx_ready;
        first_idx   = next_set(8'(frame.mask), 4'd0);
        after_idx   = next_set(8'(frame.mask), out_idx + 4'd1);
        case (state)
            S_IDLE: begin
                if (!empty) begin
                    state_n = S_HDR;
                    pop     = 1'b1;
                end
            end
            S_HDR: begin
                tx.tx_data = HDR_BYTE;
                if (fire) state_n = S_MASK;
            end
            S_MASK: begin
                tx.tx_data = 8'(frame.mask);
                if (fire) begin
                    cnt_n = '0;
`ifdef VERDICT_TS_EN
                    state_n = S_TS;
`else
                    state_n = S_DATA;
                    idx_n   = first_idx;
`endif
                end
            end
            S_TS: begin
`ifdef VERDICT_TS_EN
                tx.tx_data = ts_byte;
                if (fire) begin
                    if (cnt == CNT_W'(TS_BYTES - 1)) begin
                        state_n = S_DATA;
                        cnt_n   = '0;
                        idx_n   = first_idx;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
`else
                state_n = S_IDLE;
`endif
            end
            S_DATA: begin
                tx.tx_data = data_byte;
                if (fire) begin
                    if (cnt == CNT_W'(DATA_BYTES - 1)) begin
                        cnt_n = '0;
                        if (after_idx >= 4'(NUM_OUTPUTS)) frame_done = 1'b1;
                        else                              idx_n      = after_idx;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
            end
            default: state_n = S_IDLE;
        endcase
        if (frame_done) begin
            if (!empty) begin
                state_n = S_HDR;
                pop     = 1'b1;
            end else begin
                state_n = S_IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            cnt      <= '0;
            out_idx  <= '0;
            frame    <= '0;
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            out_idx <= idx_n;
            if (pop) frame <= rd_data;
            if (drop) begin
                overflow <= 1'b1;
                if (drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
            end
        end
    end
endmodule
